// File: rtl/qaoa_kernel_mul_rescale.sv
// Drives an external pipelined multiplier's clock-enable, tracks its valid bits, and rescales each
// product (round-half-up, saturate) into a 2-entry output FIFO with ready/valid back-pressure.
module qaoa_kernel_mul_rescale #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned PROD_WIDTH  = 141,
  parameter int unsigned FRAC_SHIFT  = 88,
  parameter int unsigned OUT_WIDTH   = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mul_ce,
  input  logic [PROD_WIDTH-1:0] prod,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  idle
);

  localparam int unsigned SumWidth = PROD_WIDTH + 1;

  logic [MUL_LATENCY-1:0] vp_q, vp_d;
  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [OUT_WIDTH:0]     mem_q [2];

  logic                   head_valid;
  logic                   push, pop, accept;
  logic [SumWidth-1:0]    sum, q;
  logic                   res_sat;
  logic [OUT_WIDTH-1:0]   res_data;

  assign head_valid = vp_q[MUL_LATENCY-1];

  // Only a real product that cannot land in a full, non-draining FIFO freezes the multiplier.
  assign mul_ce   = reset || !(head_valid && (count_q == 2'd2) && !out_ready);
  assign in_ready = mul_ce;
  assign accept   = in_valid && in_ready && !reset;
  assign push     = head_valid && mul_ce && !reset;
  assign pop      = out_valid && out_ready;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign out_sat   = mem_q[rd_ptr_q][OUT_WIDTH];
  assign idle      = (vp_q == '0) && (count_q == 2'd0);

  // One extra bit keeps the rounding carry of an all-ones product.
  always_comb begin
    sum      = {1'b0, prod} + (SumWidth'(1) << (FRAC_SHIFT - 1));
    q        = sum >> FRAC_SHIFT;
    res_sat  = |(q >> OUT_WIDTH);
    res_data = res_sat ? '1 : q[OUT_WIDTH-1:0];
  end

  always_comb begin
    vp_d    = vp_q;
    count_d = count_q + 2'(push) - 2'(pop);
    if (mul_ce) begin
      vp_d = MUL_LATENCY'({vp_q, accept});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vp_q     <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      vp_q    <= vp_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {res_sat, res_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_qaoa_kernel_mul_rescale.sv
// Bench for qaoa_kernel_mul_rescale: a ce-gated multiplier stand-in passes din through as the
// product, and a queue of arithmetically rounded results scores every popped output.
module tb_qaoa_kernel_mul_rescale;

  localparam int unsigned Lat = 4;
  localparam int unsigned Pw  = 141;
  localparam int unsigned Fs  = 88;
  localparam int unsigned Ow  = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mul_ce;
  logic [Pw-1:0] prod;
  logic [Ow-1:0] out_data;
  logic          out_sat;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          idle;
  logic [Pw-1:0] din = '0;
  logic [Pw-1:0] mpipe [Lat];

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic [63:0] exp_q [$];

  qaoa_kernel_mul_rescale #(
    .MUL_LATENCY(Lat),
    .PROD_WIDTH (Pw),
    .FRAC_SHIFT (Fs),
    .OUT_WIDTH  (Ow)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mul_ce   (mul_ce),
    .prod     (prod),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: identity "product" delayed Lat ce-enabled edges.
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= din;
      for (int i = 1; i < Lat; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign prod = mpipe[Lat-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Floor of the quotient plus the first dropped bit, then clamp.
  function automatic logic [63:0] ref_model(input logic [Pw-1:0] p);
    logic [Pw-1:0] fl;
    logic [63:0]   r;
    fl = p >> Fs;
    r  = 64'(fl) + 64'(p[Fs-1]);
    if (r > 64'hFFFF_FFFF_FFFF) return {15'd0, 1'b1, 48'hFFFF_FFFF_FFFF};
    return {15'd0, 1'b0, r[47:0]};
  endfunction

  function automatic logic [Pw-1:0] rand_prod();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[Pw-1:0] >> $urandom_range(0, Pw - 1);
  endfunction

  task automatic step(input bit r, input bit iv, input logic [Pw-1:0] d, input bit ordy);
    @(negedge clk);
    reset = r; in_valid = iv; din = d; out_ready = ordy;
    #1;
    check("ready_eq_ce", 64'(in_ready), 64'(mul_ce));
    if (r) begin
      check("ce_in_reset", 64'(mul_ce), 64'd1);
      exp_q.delete();
    end else begin
      check("idle", 64'(idle), 64'(exp_q.size() == 0));
      if (exp_q.size() == 0) check("no_stale", 64'(out_valid), 64'd0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("data", {15'd0, out_sat, out_data}, exp_q.pop_front());
        n_pop++;
      end
      if (iv && in_ready) begin
        exp_q.push_back(ref_model(d));
        n_acc++;
      end
    end
  endtask

  logic [Pw-1:0] vals [7];
  bit stalled;
  int acc_at_stall;
  int pre;

  initial begin
    for (int i = 0; i < 3; i++) step(1, 1, rand_prod(), 0);

    // Basic latency: result visible exactly Lat+1 cycles after acceptance.
    step(0, 1, Pw'(1) << 88, 1);
    for (int k = 1; k <= Lat + 1; k++) begin
      step(0, 0, '0, 1);
      check("latency", 64'(out_valid), 64'(k == Lat + 1));
    end
    step(0, 0, '0, 1);
    check("idle_after_one", 64'(idle), 64'd1);

    // Rounding, saturation and carry corner cases.
    vals[0] = Pw'(3) << 87;
    vals[1] = (Pw'(1) << 87) - 1;
    vals[2] = Pw'(1) << 87;
    vals[3] = Pw'(1) << 136;
    vals[4] = '1;
    vals[5] = (Pw'(1) << 136) - 1;
    vals[6] = ((Pw'(1) << 48) - 1) << 88;
    for (int i = 0; i < 7; i++) step(0, 1, vals[i], 1);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
    check("corner_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: 8 operands against a stalled consumer.
    n_acc = 0; n_pop = 0; stalled = 0; acc_at_stall = 0;
    for (int k = 0; k < 40 && n_acc < 8; k++) begin
      step(0, 1, rand_prod(), 0);
      if (!in_ready && !stalled) begin
        stalled = 1;
        acc_at_stall = n_acc;
      end
    end
    check("bp_stall_seen", 64'(stalled), 64'd1);
    check("bp_fill", 64'(acc_at_stall), 64'd6);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, 0);
      check("bp_hold", 64'(in_ready), 64'd0);
    end
    for (int k = 0; k < 30 && (n_acc < 8 || exp_q.size() > 0); k++) begin
      pre = exp_q.size();
      step(0, n_acc < 8, rand_prod(), 1);
      if (k == 0) check("pushpop_ce", 64'(mul_ce), 64'd1);
      if (pre > 0) check("bp_no_gap", 64'(out_valid), 64'd1);
    end
    check("bp_count", 64'(n_pop), 64'd8);

    // Reset with 3 operands in the pipe and 2 buffered.
    for (int k = 0; k < 5; k++) step(0, 1, rand_prod(), 0);
    step(0, 0, '0, 0);
    check("pre_reset_busy", 64'(idle), 64'd0);
    step(1, 1, rand_prod(), 1);
    step(0, 0, '0, 1);
    check("post_reset_valid", 64'(out_valid), 64'd0);
    check("post_reset_idle", 64'(idle), 64'd1);
    for (int k = 0; k < 10; k++) step(0, 0, '0, 1);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rand_prod(),
           $urandom_range(0, 3) != 0);
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step(0, 0, '0, 1);
    check("final_drain", 64'(exp_q.size()), 64'd0);
    step(0, 0, '0, 1);
    check("final_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
